// File: rtl/fft_ctrl_pkg.sv
// Shared types and defaults for the radix-2 SDF stage sequencer.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        BFLY,
        DRAIN
    } state_e;

    localparam int DEF_REG_DEPTH    = 16;
    localparam int DEF_FRAME_CYCLES = 2 * DEF_REG_DEPTH;

    // Width of a counter that indexes 0..n-1; never narrower than one bit.
    function automatic int calc_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fft_sdf_stage_ctrl.sv
// Per-cycle control sequencer for one radix-2 SDF stage whose delay line shifts every cycle.
// Tracks frame position, drives butterfly/feedback selects and output framing, polices upstream beats.
module fft_sdf_stage_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int REG_DEPTH    = DEF_REG_DEPTH,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int CNT_W        = calc_cnt_w(FRAME_CYCLES),
    parameter int FCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic              bfly_sel,
    output logic              fb_sel,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic              err_proto,
    output logic [FCNT_W-1:0] frame_cnt
);

    if (FRAME_CYCLES != 2 * REG_DEPTH) begin : g_cfg_check
        $error("fft_sdf_stage_ctrl: FRAME_CYCLES must equal 2*REG_DEPTH");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_FIRST = CNT_W'(REG_DEPTH);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(REG_DEPTH - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: this block has no storage arrays; every flop is reset, so a mid-frame reset is clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        frame_cnt_d = frame_cnt_q;
        in_ready    = 1'b0;
        bfly_sel    = 1'b0;
        fb_sel      = 1'b0;
        out_valid   = 1'b0;
        out_sof     = 1'b0;
        out_eof     = 1'b0;
        err_proto   = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                cnt_d    = CNT_ZERO;
                pend_d   = 1'b0;
                if (in_valid && in_sof) begin
                    state_d = FILL;
                    cnt_d   = CNT_ONE;
                end
            end

            FILL: begin
                // While pend is set, the previous frame's differences drain alongside this fill.
                in_ready  = 1'b1;
                out_valid = pend_q & in_valid;
                out_eof   = pend_q & in_valid & (cnt_q == HALF_LAST);
                if (!in_valid) begin
                    err_proto = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    pend_d    = 1'b0;
                end else if (in_sof) begin
                    err_proto = 1'b1;
                    cnt_d     = CNT_ONE;
                    pend_d    = 1'b0;
                end else if (cnt_q == HALF_LAST) begin
                    state_d = BFLY;
                    cnt_d   = HALF_FIRST;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            BFLY: begin
                in_ready  = 1'b1;
                bfly_sel  = 1'b1;
                fb_sel    = 1'b1;
                out_valid = in_valid;
                out_sof   = in_valid & (cnt_q == HALF_FIRST);
                if (!in_valid) begin
                    err_proto = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    pend_d    = 1'b0;
                end else if (in_sof) begin
                    err_proto = 1'b1;
                    state_d   = FILL;
                    cnt_d     = CNT_ONE;
                    pend_d    = 1'b0;
                end else if (cnt_q == FRAME_LAST) begin
                    state_d     = DRAIN;
                    cnt_d       = CNT_ZERO;
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DRAIN: begin
                // Only the first drain cycle may accept a new frame, overlapping it with the drain.
                in_ready  = (cnt_q == CNT_ZERO);
                out_valid = 1'b1;
                out_eof   = (cnt_q == HALF_LAST);
                if ((cnt_q == CNT_ZERO) && in_valid && in_sof) begin
                    state_d = FILL;
                    cnt_d   = CNT_ONE;
                    pend_d  = 1'b1;
                end else if (cnt_q == HALF_LAST) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed self-checking bench for fft_sdf_stage_ctrl (REG_DEPTH=16, FRAME_CYCLES=32).
module tb_fft_sdf_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready, bfly_sel, fb_sel, out_valid, out_sof, out_eof, busy, err_proto;
    logic [15:0] frame_cnt;
    logic [7:0]  obs;

    int n_checks = 0;
    int n_errors = 0;
    int ov_count = 0;

    fft_sdf_stage_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .bfly_sel  (bfly_sel),
        .fb_sel    (fb_sel),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .busy      (busy),
        .err_proto (err_proto),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Packed view: {in_ready, bfly_sel, fb_sel, out_valid, out_sof, out_eof, busy, err_proto}
    assign obs = {in_ready, bfly_sel, fb_sel, out_valid, out_sof, out_eof, busy, err_proto};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic v, input logic s);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sof   = s;
        @(negedge clk);
        if (out_valid) ov_count++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset outputs", obs, 8'h80);
        check("reset frame_cnt", frame_cnt, 0);
        ov_count = 0;
    endtask

    // Continuous valid beats first..last of a frame; p = previous frame still draining.
    task automatic beats(input int first, input int last, input bit p);
        for (int b = first; b <= last; b++) begin
            cyc(1'b1, b == 0);
            check($sformatf("beat %0d p=%0d", b, p), obs,
                  {1'b1, b >= 16, b >= 16, (b >= 16) || p, b == 16, p && (b == 15), (b != 0) || p, 1'b0});
        end
    endtask

    // Sixteen drain cycles with no new frame; a sof beat is offered at drain index blk.
    task automatic drain(input int blk);
        for (int d = 0; d < 16; d++) begin
            cyc(d == blk, d == blk);
            check($sformatf("drain %0d", d), obs,
                  {d == 0, 1'b0, 1'b0, 1'b1, 1'b0, d == 15, 1'b1, 1'b0});
        end
        cyc(1'b0, 1'b0);
        check("idle after drain", obs, 8'h80);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single frame
        do_reset();
        beats(0, 31, 1'b0);
        drain(-1);
        check("t1 frame_cnt", frame_cnt, 1);
        check("t1 out_valid count", ov_count, 32);

        // Three back-to-back frames, sof on the first drain cycle each time
        do_reset();
        beats(0, 31, 1'b0);
        beats(0, 31, 1'b1);
        beats(0, 31, 1'b1);
        drain(-1);
        check("t2 frame_cnt", frame_cnt, 3);
        check("t2 out_valid count", ov_count, 96);

        // Gap at beat 20
        do_reset();
        beats(0, 19, 1'b0);
        cyc(1'b0, 1'b0);
        check("t3 gap beat", obs, 8'b1110_0011);
        cyc(1'b0, 1'b0);
        check("t3 idle after gap", obs, 8'h80);
        check("t3 frame_cnt", frame_cnt, 0);

        // Misplaced sof at beat 9 restarts the frame
        do_reset();
        beats(0, 8, 1'b0);
        cyc(1'b1, 1'b1);
        check("t4 misplaced sof", obs, 8'b1000_0011);
        beats(1, 31, 1'b0);
        drain(-1);
        check("t4 frame_cnt", frame_cnt, 1);

        // Sof offered at drain index 5 is refused; a later sof starts normally
        do_reset();
        beats(0, 31, 1'b0);
        drain(5);
        beats(0, 31, 1'b0);
        drain(-1);
        check("t5 frame_cnt", frame_cnt, 2);

        // Reset asserted during BFLY beat 25
        beats(0, 24, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        @(negedge clk);
        check("t6 beat 25 before reset", obs, 8'b1111_0010);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6 after reset", obs, 8'h80);
        check("t6 frame_cnt", frame_cnt, 0);
        cyc(1'b1, 1'b0);
        check("t6 beat without sof dropped", obs, 8'h80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
